// File: rtl/ula_pkg.sv
// Shared opcode encoding and datapath width for the 8-bit structural ALU.
package ula_pkg;

   localparam int unsigned ULA_W = 8;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_NOT = 3'b100
   } ula_op_e;

endpackage

// File: rtl/ula_8bit_structure_full_add_sub_1bit.sv
// One-bit cell of the ripple chain: full adder when sub=0, full subtractor when sub=1.
module full_add_sub_1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic sub,
   output logic s,
   output logic cout
);

   logic a_eff;

   // Inverting a turns the adder majority into the borrow term (~a&b)|(~a&cin)|(b&cin).
   assign a_eff = a ^ sub;
   assign s     = a ^ b ^ cin;
   assign cout  = (a_eff & b) | (a_eff & cin) | (b & cin);

endmodule

// File: rtl/ula_8bit_structure.sv
// 8-bit ALU: ripple add/sub chain, per-bit logic gates, opcode mux, one output register.
module ula_8bit_structure
   import ula_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             cin,
   input  logic [ULA_W-1:0] a,
   input  logic [ULA_W-1:0] b,
   input  logic [2:0]       x,
   output logic [ULA_W-1:0] s,
   output logic             cout
);

   logic [ULA_W:0]   chain_c;
   logic [ULA_W-1:0] arith_r;
   logic [ULA_W-1:0] and_r;
   logic [ULA_W-1:0] or_r;
   logic [ULA_W-1:0] not_r;
   logic             sub_sel;
   logic [ULA_W-1:0] s_d;
   logic [ULA_W-1:0] s_q;
   logic             cout_d;
   logic             cout_q;

   assign sub_sel    = (x == OP_SUB);
   assign chain_c[0] = cin;

   for (genvar i = 0; i < ULA_W; i++) begin : g_bit
      full_add_sub_1bit u_cell (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (chain_c[i]),
         .sub  (sub_sel),
         .s    (arith_r[i]),
         .cout (chain_c[i+1])
      );
      assign and_r[i] = a[i] & b[i];
      assign or_r[i]  = a[i] | b[i];
      assign not_r[i] = ~a[i];
   end

   always_comb begin
      s_d    = '0;
      cout_d = 1'b0;
      case (x)
         OP_ADD,
         OP_SUB: begin
            s_d    = arith_r;
            cout_d = chain_c[ULA_W];
         end
         OP_AND:  s_d = and_r;
         OP_OR:   s_d = or_r;
         OP_NOT:  s_d = not_r;
         default: s_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q    <= '0;
         cout_q <= 1'b0;
      end else begin
         s_q    <= s_d;
         cout_q <= cout_d;
      end
   end

   assign s    = s_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_ula_8bit_structure.sv
// Scoreboard bench for ula_8bit_structure: directed vectors, reset cases, random ops.
module tb_ula_8bit_structure;

   logic       clk = 1'b0;
   logic       rst;
   logic       cin;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] x;
   logic [7:0] s;
   logic       cout;

   typedef struct {
      logic [7:0] s;
      logic       c;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   stim_done = 1'b0;

   ula_8bit_structure dut (
      .clk  (clk),
      .rst  (rst),
      .cin  (cin),
      .a    (a),
      .b    (b),
      .x    (x),
      .s    (s),
      .cout (cout)
   );

   always #5 clk = ~clk;

   function automatic void model(input logic [2:0] op, input logic [7:0] oa,
                                 input logic [7:0] ob, input logic ci,
                                 output logic [7:0] r, output logic c);
      int unsigned t;
      r = 8'h00;
      c = 1'b0;
      case (op)
         3'd0: begin
            t = oa + ob + ci;
            r = t[7:0];
            c = t[8];
         end
         3'd1: begin
            t = 256 + oa - ob - ci;
            r = t[7:0];
            c = (int'(oa) < int'(ob) + int'(ci));
         end
         3'd2: r = oa & ob;
         3'd3: r = oa | ob;
         3'd4: r = ~oa;
         default: ;
      endcase
   endfunction

   task automatic check(input string name, input logic [7:0] got_s, input logic got_c,
                        input logic [7:0] want_s, input logic want_c);
      checks++;
      if (got_s !== want_s || got_c !== want_c) begin
         errors++;
         $display("FAIL %s: got s=%h cout=%b, expected s=%h cout=%b",
                  name, got_s, got_c, want_s, want_c);
      end
   endtask

   // Drive between edges and record the response expected after the next edge.
   task automatic issue(input logic [2:0] op, input logic [7:0] oa, input logic [7:0] ob,
                        input logic ci, input string name);
      exp_t e;
      @(negedge clk);
      x   = op;
      a   = oa;
      b   = ob;
      cin = ci;
      model(op, oa, ob, ci, e.s, e.c);
      e.name = name;
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name, s, cout, e.s, e.c);
         end
      end
   end

   initial begin : driver
      rst = 1'b1;
      cin = 1'b0;
      a   = 8'h00;
      b   = 8'h00;
      x   = 3'b000;
      #2;
      check("reset_async", s, cout, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      check("reset_hold", s, cout, 8'h00, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      issue(3'b000, 8'h83, 8'h01, 1'b0, "add_83_01");
      issue(3'b000, 8'h13, 8'h11, 1'b0, "add_13_11");
      issue(3'b000, 8'hFF, 8'h01, 1'b0, "add_ff_01");
      issue(3'b000, 8'hFF, 8'hFF, 1'b1, "add_ff_ff_c");
      issue(3'b001, 8'h83, 8'h01, 1'b0, "sub_83_01");
      issue(3'b001, 8'h92, 8'h06, 1'b0, "sub_92_06");
      issue(3'b001, 8'h00, 8'h01, 1'b0, "sub_00_01");
      issue(3'b001, 8'h05, 8'h02, 1'b1, "sub_05_02_c");
      issue(3'b001, 8'h5A, 8'h5A, 1'b0, "sub_eq");
      issue(3'b001, 8'h5A, 8'h5A, 1'b1, "sub_eq_c");
      issue(3'b010, 8'h83, 8'h01, 1'b1, "and_83_01");
      issue(3'b010, 8'hFF, 8'hA9, 1'b0, "and_ff_a9");
      issue(3'b011, 8'h83, 8'h01, 1'b0, "or_83_01");
      issue(3'b011, 8'h9D, 8'h9F, 1'b1, "or_9d_9f");
      issue(3'b100, 8'h83, 8'h55, 1'b0, "not_83");
      issue(3'b101, 8'hFF, 8'hFF, 1'b1, "rsv_101");
      issue(3'b110, 8'h12, 8'h34, 1'b0, "rsv_110");
      issue(3'b111, 8'hAB, 8'hCD, 1'b1, "rsv_111");
      issue(3'b100, 8'h00, 8'h00, 1'b0, "not_00");

      // s is now FF; reset asserted between edges must clear it without a clock.
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("rst_midcycle", s, cout, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      check("rst_over_edge", s, cout, 8'h00, 1'b0);
      issue(3'b000, 8'hFF, 8'h01, 1'b0, "after_release");
      rst = 1'b0;

      for (int i = 0; i < 200; i++) begin
         issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
               1'($urandom_range(0, 1)), "random");
      end

      stim_done = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expected results left unchecked, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #50000;
      $display("FAIL timeout: simulation did not complete within time budget");
      $fatal(1);
   end

endmodule
